// File: rtl/lsu_pkg.sv
// lsu_pkg -- shared definitions for the load/store unit.
//   SIZE_*               access-size encoding (same as the decoder's
//                        mux_load_byte_half_word select)
//   lsu_state_e          FSM state encoding
//   TIMEOUT_CYC_DEFAULT  default bound on an unacknowledged mem_req
//   start_is_bad()       request legality check done in IDLE
package lsu_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_ILL  = 2'b11;

    localparam int unsigned TIMEOUT_CYC_DEFAULT = 255;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD    = 3'd1,
        MERGE = 3'd2,
        WR    = 3'd3,
        FIN   = 3'd4
    } lsu_state_e;

    // A request is rejected without touching memory when the op is
    // ambiguous (both or neither of read/write), the size is the
    // reserved code, or the address is not naturally aligned.
    function automatic logic start_is_bad(input logic       rd,
                                          input logic       wr,
                                          input logic [1:0] sz,
                                          input logic [1:0] lo);
        logic bad;
        bad = (rd == wr) || (sz == SIZE_ILL);
        if (sz == SIZE_HALF && lo[0])
            bad = 1'b1;
        if (sz == SIZE_WORD && lo != 2'b00)
            bad = 1'b1;
        return bad;
    endfunction

endpackage

// File: rtl/lsu_lane_mux.sv
// lsu_lane_mux -- byte-lane steering for the load/store unit (pure
// combinational, little-endian lanes).
//   word_i      memory word being read or modified
//   addr_lo     byte offset within the word
//   size        SIZE_BYTE / SIZE_HALF / SIZE_WORD
//   store_data  store data; only the low byte/half is used for sub-word
//   load_val    addressed lane of word_i, zero-extended
//   merged      word_i with the addressed lane replaced by store_data
module lsu_lane_mux
    import lsu_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic [31:0] store_data,
    output logic [31:0] load_val,
    output logic [31:0] merged
);

    always_comb begin
        // NOTE: every output gets a default before the case, so no path
        // through this block can leave an inferred latch behind.
        load_val = 32'h0;
        merged   = word_i;
        case (size)
            SIZE_BYTE: begin
                load_val[7:0]                       = word_i[{addr_lo, 3'b000} +: 8];
                merged[{addr_lo, 3'b000} +: 8]      = store_data[7:0];
            end
            SIZE_HALF: begin
                load_val[15:0]                      = word_i[{addr_lo[1], 4'b0000} +: 16];
                merged[{addr_lo[1], 4'b0000} +: 16] = store_data[15:0];
            end
            default: begin
                load_val = word_i;
                merged   = store_data;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit -- multi-cycle data-memory access engine.
// Loads (LBU/LHU/LW, zero-extended) and stores (SB/SH/SW) against a
// word-addressed memory with a req/ack handshake. Sub-word stores are
// done as read / merge / write.
//   clk, rst       clock, synchronous active-high reset
//   start          one-cycle request strobe, accepted in IDLE only
//   read_mem,
//   write_mem      decoder op controls (exactly one must be set)
//   size, addr     access size and byte address
//   wdata          store data
//   busy           high from the cycle after start until done
//   done, err      one-cycle completion pulse and its error flag
//   rdata          zero-extended load result, held until next done
//   mem_req/we     memory request and write enable
//   mem_addr       word-aligned address
//   mem_wdata      full-word write data
//   mem_ack        one-cycle acknowledge (read data valid with it)
//   mem_rdata      memory read word
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        read_mem,
    input  logic        write_mem,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

    lsu_state_e       state_q,     state_d;
    logic             busy_q,      busy_d;
    logic             done_q,      done_d;
    logic             err_q,       err_d;
    logic [31:0]      rdata_q,     rdata_d;
    logic             mem_req_q,   mem_req_d;
    logic             mem_we_q,    mem_we_d;
    logic [31:0]      mem_addr_q,  mem_addr_d;
    logic [31:0]      mem_wdata_q, mem_wdata_d;
    logic [CNT_W-1:0] tmo_cnt_q,   tmo_cnt_d;
    logic [1:0]       addr_lo_q,   addr_lo_d;
    logic [1:0]       size_q,      size_d;
    logic [31:0]      wdata_q,     wdata_d;
    logic             is_load_q,   is_load_d;
    logic             err_pend_q,  err_pend_d;
    // Holds the extracted load value, or the captured memory word while
    // a sub-word store waits for its merge.
    logic [31:0]      word_q,      word_d;

    logic        ack;
    logic        tmo_hit;
    logic [31:0] lane_word;
    logic [31:0] lane_load;
    logic [31:0] lane_merged;

    // An ack outside a request phase is meaningless and must not move
    // the FSM.
    assign ack = mem_req_q & mem_ack;

    // The counter holds the number of unacknowledged cycles already
    // spent; the current cycle is the last allowed one when +1 reaches
    // the limit.
    assign tmo_hit = (TIMEOUT_CYC != 0) && ((32'(tmo_cnt_q) + 32'd1) == TIMEOUT_CYC);

    // RD extracts from the live bus word; MERGE modifies the captured one.
    assign lane_word = (state_q == MERGE) ? word_q : mem_rdata;

    lsu_lane_mux u_lane_mux (
        .word_i     (lane_word),
        .addr_lo    (addr_lo_q),
        .size       (size_q),
        .store_data (wdata_q),
        .load_val   (lane_load),
        .merged     (lane_merged)
    );

    always_comb begin
        state_d     = state_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        rdata_d     = rdata_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        tmo_cnt_d   = tmo_cnt_q;
        addr_lo_d   = addr_lo_q;
        size_d      = size_q;
        wdata_d     = wdata_q;
        is_load_d   = is_load_q;
        err_pend_d  = err_pend_q;
        word_d      = word_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (start_is_bad(read_mem, write_mem, size, addr[1:0])) begin
                        err_pend_d = 1'b1;
                        state_d    = FIN;
                    end else begin
                        err_pend_d = 1'b0;
                        addr_lo_d  = addr[1:0];
                        size_d     = size;
                        wdata_d    = wdata;
                        is_load_d  = read_mem;
                        mem_addr_d = {addr[31:2], 2'b00};
                        if (read_mem) begin
                            state_d = RD;
                        end else if (size == SIZE_WORD) begin
                            mem_wdata_d = wdata;
                            state_d     = WR;
                        end else begin
                            state_d = RD;
                        end
                    end
                end
            end

            RD: begin
                if (ack) begin
                    if (is_load_q) begin
                        word_d  = lane_load;
                        state_d = FIN;
                    end else begin
                        word_d  = mem_rdata;
                        state_d = MERGE;
                    end
                end else if (tmo_hit) begin
                    err_pend_d = 1'b1;
                    state_d    = FIN;
                end else if (TIMEOUT_CYC != 0) begin
                    tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
                end
            end

            MERGE: begin
                mem_wdata_d = lane_merged;
                state_d     = WR;
            end

            WR: begin
                if (ack) begin
                    state_d = FIN;
                end else if (tmo_hit) begin
                    err_pend_d = 1'b1;
                    state_d    = FIN;
                end else if (TIMEOUT_CYC != 0) begin
                    tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
                end
            end

            FIN: begin
                // Registered completion: done/err/rdata change together on
                // the edge that returns to IDLE. A failed access keeps the
                // previous load result.
                done_d = 1'b1;
                err_d  = err_pend_q;
                if (is_load_q && !err_pend_q)
                    rdata_d = word_q;
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase

        // Each request phase gets a fresh timeout budget.
        if ((state_d == RD || state_d == WR) && state_d != state_q)
            tmo_cnt_d = '0;

        // Bus controls are registered straight from the next state, so
        // mem_req drops on the same edge that samples the ack.
        mem_req_d = (state_d == RD) || (state_d == WR);
        mem_we_d  = (state_d == WR);
        busy_d    = (state_d != IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= 32'h0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
            tmo_cnt_q   <= '0;
            addr_lo_q   <= 2'b00;
            size_q      <= SIZE_BYTE;
            wdata_q     <= 32'h0;
            is_load_q   <= 1'b0;
            err_pend_q  <= 1'b0;
            word_q      <= 32'h0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            tmo_cnt_q   <= tmo_cnt_d;
            addr_lo_q   <= addr_lo_d;
            size_q      <= size_d;
            wdata_q     <= wdata_d;
            is_load_q   <= is_load_d;
            err_pend_q  <= err_pend_d;
            word_q      <= word_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign rdata     = rdata_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit -- directed, table-driven bench for load_store_unit
// with a small word memory model that answers mem_req after a
// programmable delay.
module tb_load_store_unit;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        read_mem = 1'b0;
    logic        write_mem = 1'b0;
    logic [1:0]  size = 2'b00;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        busy, done, err, mem_req, mem_we;
    logic [31:0] rdata, mem_addr, mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'h0;

    load_store_unit #(.TIMEOUT_CYC(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .read_mem  (read_mem),
        .write_mem (write_mem),
        .size      (size),
        .addr      (addr),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .rdata     (rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // ---------------- memory model ----------------
    logic [31:0] mem [0:63];
    int          ack_delay = 0;
    bit          ack_en = 1'b1;
    bit          stray_ack = 1'b0;
    int          req_cycles = 0;
    int          req_phases = 0;
    int          wr_count = 0;
    logic [31:0] last_maddr = 32'h0;
    logic [31:0] last_wdata = 32'h0;
    logic        req_prev = 1'b0;
    int          wait_cnt = 0;

    always @(negedge clk) begin
        if (mem_req) begin
            req_cycles++;
            if (!req_prev) begin
                req_phases++;
                last_maddr = mem_addr;
            end
        end
        req_prev = mem_req;
        if (mem_req && ack_en) begin
            if (wait_cnt >= ack_delay) begin
                mem_ack   = 1'b1;
                mem_rdata = mem[mem_addr[7:2]];
                if (mem_we) begin
                    wr_count++;
                    last_wdata = mem_wdata;
                end
                wait_cnt = 0;
            end else begin
                mem_ack = 1'b0;
                wait_cnt++;
            end
        end else begin
            mem_ack  = stray_ack;
            wait_cnt = 0;
        end
    end

    // ---------------- checking ----------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Issue one request; report done latency in edges after E0 (-1 if it
    // never arrives), the result and busy in the cycle after start.
    task automatic do_op(input logic rm, input logic wm, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] wd,
                         output int lat, output logic [31:0] rd,
                         output logic er, output logic bsy0);
        @(negedge clk);
        read_mem  = rm;
        write_mem = wm;
        size      = sz;
        addr      = a;
        wdata     = wd;
        start     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        bsy0  = busy;
        lat   = -1;
        rd    = 32'h0;
        er    = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (done) begin
                lat = k;
                rd  = rdata;
                er  = err;
                break;
            end
            @(negedge clk);
        end
    endtask

    typedef struct {
        string       name;
        logic        rm, wm;
        logic [1:0]  sz;
        logic [31:0] addr, wdata, init, exp_rd;
        logic        exp_err;
        int          exp_lat, exp_ph;
        logic        chk_wr;
        logic [31:0] exp_wr;
    } vec_t;

    function automatic vec_t mk(input string n, input logic rm, input logic wm,
                                input logic [1:0] sz, input logic [31:0] a,
                                input logic [31:0] wd, input logic [31:0] init,
                                input logic [31:0] exp_rd, input logic exp_err,
                                input int lat, input int ph, input logic chk_wr,
                                input logic [31:0] exp_wr);
        vec_t v;
        v.name = n; v.rm = rm; v.wm = wm; v.sz = sz; v.addr = a; v.wdata = wd;
        v.init = init; v.exp_rd = exp_rd; v.exp_err = exp_err; v.exp_lat = lat;
        v.exp_ph = ph; v.chk_wr = chk_wr; v.exp_wr = exp_wr;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vq[$];
        int          lat, ph0, wr0, rc0;
        logic [31:0] rd;
        logic        er, bsy0;
        int          done_seen;
        logic [31:0] RD_HOLD;

        for (int i = 0; i < 64; i++) mem[i] = 32'h0;

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset busy", 32'(busy), 0);
        check("reset done", 32'(done), 0);
        check("reset err", 32'(err), 0);
        check("reset mem_req", 32'(mem_req), 0);
        check("reset mem_we", 32'(mem_we), 0);
        check("reset rdata", rdata, 0);
        check("reset mem_addr", mem_addr, 0);
        check("reset mem_wdata", mem_wdata, 0);
        rst = 1'b0;

        RD_HOLD = 32'h0F1E2D3C;  // last successful load in the table
        vq.push_back(mk("LBU 103", 1,0,SIZE_BYTE,32'h103,0,32'hAABBCCDD,32'h000000AA,0,2,1,0,0));
        vq.push_back(mk("LHU 102", 1,0,SIZE_HALF,32'h102,0,32'hAABBCCDD,32'h0000AABB,0,2,1,0,0));
        vq.push_back(mk("LW 100",  1,0,SIZE_WORD,32'h100,0,32'hAABBCCDD,32'hAABBCCDD,0,2,1,0,0));
        vq.push_back(mk("LBU 100", 1,0,SIZE_BYTE,32'h100,0,32'hAABBCCDD,32'h000000DD,0,2,1,0,0));
        vq.push_back(mk("LHU 100", 1,0,SIZE_HALF,32'h100,0,32'hAABBCCDD,32'h0000CCDD,0,2,1,0,0));
        vq.push_back(mk("LBU 101", 1,0,SIZE_BYTE,32'h101,0,32'hAABBCCDD,32'h000000CC,0,2,1,0,0));
        vq.push_back(mk("LW 104",  1,0,SIZE_WORD,32'h104,0,32'h0F1E2D3C,RD_HOLD,0,2,1,0,0));
        vq.push_back(mk("SB 101",  0,1,SIZE_BYTE,32'h101,32'h00000055,32'h11223344,RD_HOLD,0,4,2,1,32'h11225544));
        vq.push_back(mk("SH 102",  0,1,SIZE_HALF,32'h102,32'h1234BEEF,32'h11223344,RD_HOLD,0,4,2,1,32'hBEEF3344));
        vq.push_back(mk("SB 103",  0,1,SIZE_BYTE,32'h103,32'hFFFFFF77,32'h11223344,RD_HOLD,0,4,2,1,32'h77223344));
        vq.push_back(mk("SB 100",  0,1,SIZE_BYTE,32'h100,32'h000000A5,32'h11223344,RD_HOLD,0,4,2,1,32'h112233A5));
        vq.push_back(mk("SH 104",  0,1,SIZE_HALF,32'h104,32'h0000CAFE,32'h55667788,RD_HOLD,0,4,2,1,32'h5566CAFE));
        vq.push_back(mk("SW 100",  0,1,SIZE_WORD,32'h100,32'hDEADBEEF,32'h11223344,RD_HOLD,0,2,1,1,32'hDEADBEEF));
        vq.push_back(mk("LW 102 misaligned", 1,0,SIZE_WORD,32'h102,0,32'h11223344,RD_HOLD,1,1,0,0,0));
        vq.push_back(mk("SH 101 misaligned", 0,1,SIZE_HALF,32'h101,32'h1,32'h11223344,RD_HOLD,1,1,0,0,0));
        vq.push_back(mk("LHU 103 misaligned",1,0,SIZE_HALF,32'h103,0,32'h11223344,RD_HOLD,1,1,0,0,0));
        vq.push_back(mk("SW 101 misaligned", 0,1,SIZE_WORD,32'h101,32'h1,32'h11223344,RD_HOLD,1,1,0,0,0));
        vq.push_back(mk("size 11",           1,0,SIZE_ILL, 32'h100,0,32'h11223344,RD_HOLD,1,1,0,0,0));
        vq.push_back(mk("rd=wr=1",           1,1,SIZE_WORD,32'h100,0,32'h11223344,RD_HOLD,1,1,0,0,0));
        vq.push_back(mk("rd=wr=0",           0,0,SIZE_WORD,32'h100,0,32'h11223344,RD_HOLD,1,1,0,0,0));

        foreach (vq[i]) begin
            mem[vq[i].addr[7:2]] = vq[i].init;
            ph0 = req_phases;
            wr0 = wr_count;
            do_op(vq[i].rm, vq[i].wm, vq[i].sz, vq[i].addr, vq[i].wdata, lat, rd, er, bsy0);
            check({vq[i].name, " latency"}, 32'(lat), 32'(vq[i].exp_lat));
            check({vq[i].name, " busy"}, 32'(bsy0), 1);
            check({vq[i].name, " err"}, 32'(er), 32'(vq[i].exp_err));
            check({vq[i].name, " rdata"}, rd, vq[i].exp_rd);
            check({vq[i].name, " req phases"}, 32'(req_phases - ph0), 32'(vq[i].exp_ph));
            check({vq[i].name, " writes"}, 32'(wr_count - wr0), vq[i].chk_wr ? 32'd1 : 32'd0);
            if (vq[i].exp_ph > 0)
                check({vq[i].name, " mem_addr"}, last_maddr, {vq[i].addr[31:2], 2'b00});
            if (vq[i].chk_wr)
                check({vq[i].name, " mem_wdata"}, last_wdata, vq[i].exp_wr);
        end

        // Slow memory: ack in the third request cycle stretches latency.
        mem[0]    = 32'h13579BDF;
        ack_delay = 2;
        rc0       = req_cycles;
        do_op(1, 0, SIZE_WORD, 32'h100, 0, lat, rd, er, bsy0);
        check("slow LW latency", 32'(lat), 4);
        check("slow LW req cycles", 32'(req_cycles - rc0), 3);
        check("slow LW rdata", rd, 32'h13579BDF);
        ack_delay = 0;

        // Start held through RD and FIN carrying a store: must be ignored.
        mem[0] = 32'h2468ACE0;
        ph0 = req_phases;
        wr0 = wr_count;
        @(negedge clk);
        read_mem = 1; write_mem = 0; size = SIZE_WORD; addr = 32'h100; start = 1;
        @(posedge clk);
        @(negedge clk);
        read_mem = 0; write_mem = 1; wdata = 32'hFFFFFFFF;
        repeat (2) @(negedge clk);
        start = 0;
        check("busy-start done", 32'(done), 1);
        check("busy-start rdata", rdata, 32'h2468ACE0);
        repeat (6) @(negedge clk);
        check("busy-start phases", 32'(req_phases - ph0), 1);
        check("busy-start writes", 32'(wr_count - wr0), 0);

        // Ack with no request outstanding does nothing.
        stray_ack = 1;
        done_seen = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (done || busy || mem_req) done_seen++;
        end
        stray_ack = 0;
        @(negedge clk);
        check("stray ack activity", 32'(done_seen), 0);

        // Timeout with ack tied low: four request cycles, then err.
        ack_en = 0;
        rc0    = req_cycles;
        do_op(1, 0, SIZE_WORD, 32'h104, 0, lat, rd, er, bsy0);
        check("timeout latency", 32'(lat), 5);
        check("timeout err", 32'(er), 1);
        check("timeout req cycles", 32'(req_cycles - rc0), 4);
        check("timeout rdata held", rd, 32'h2468ACE0);
        check("timeout mem_req low", 32'(mem_req), 0);
        ack_en = 1;
        mem[1] = 32'h0A0B0C0D;
        do_op(1, 0, SIZE_WORD, 32'h104, 0, lat, rd, er, bsy0);
        check("post-timeout LW latency", 32'(lat), 2);
        check("post-timeout LW err", 32'(er), 0);
        check("post-timeout LW rdata", rd, 32'h0A0B0C0D);

        // Reset while a word store waits in WR.
        ack_en = 0;
        wr0    = wr_count;
        @(negedge clk);
        read_mem = 0; write_mem = 1; size = SIZE_WORD; addr = 32'h100;
        wdata = 32'h0BADF00D; start = 1;
        @(posedge clk);
        @(negedge clk);
        start = 0;
        check("WR mem_req", 32'(mem_req), 1);
        check("WR mem_we", 32'(mem_we), 1);
        check("WR mem_wdata", mem_wdata, 32'h0BADF00D);
        check("WR mem_addr", mem_addr, 32'h100);
        rst = 1;
        @(posedge clk);
        @(negedge clk);
        check("rst-in-WR mem_req", 32'(mem_req), 0);
        check("rst-in-WR busy", 32'(busy), 0);
        check("rst-in-WR done", 32'(done), 0);
        check("rst-in-WR rdata", rdata, 0);
        rst = 0;
        ack_en = 1;
        done_seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done || mem_req) done_seen++;
        end
        check("rst-in-WR no done", 32'(done_seen), 0);
        check("rst-in-WR no write", 32'(wr_count - wr0), 0);
        do_op(1, 0, SIZE_BYTE, 32'h106, 0, lat, rd, er, bsy0);
        check("post-reset LBU latency", 32'(lat), 2);
        check("post-reset LBU rdata", rd, 32'h0000000B);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Multi-cycle data-memory access engine. It consumes the decoder's read_mem / write_mem / mux_load_byte_half_word controls and drives a word-addressed data memory through a req/ack handshake. It performs byte, half and word loads with zero-extension (LBU/LHU/LW), and word, half and byte stores (SW/SH/SB). Sub-word stores use read-modify-write. The datapath stalls on busy and collects the result on done.

Parameters:
TIMEOUT_CYC, 255, max cycles mem_req may stay high without mem_ack; 0 disables the timeout.

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
start  in  1  one-cycle request strobe; ignored while busy
read_mem  in  1  load request (decoder encoding)
write_mem  in  1  store request (decoder encoding)
size  in  2  00=byte, 01=half, 10=word, 11=illegal (same encoding as mux_load_byte_half_word)
addr  in  32  byte address
wdata  in  32  store data; low byte/half used for sub-word stores
busy  out  1  high from the cycle after start until done
done  out  1  one-cycle completion pulse
err  out  1  valid with done: misaligned, illegal size, read_mem=write_mem=1, or timeout
rdata  out  32  zero-extended load result, valid with done, held until next done
mem_req  out  1  memory request, held until mem_ack sampled
mem_we  out  1  write enable, stable while mem_req=1
mem_addr  out  32  word-aligned address {addr[31:2],2'b00}
mem_wdata  out  32  full-word write data
mem_ack  in  1  one-cycle acknowledge; rdata valid in the same cycle for reads
mem_rdata  in  32  memory read word

Behaviour:
- Reset: state IDLE; busy, done, err, mem_req, mem_we = 0; rdata, mem_addr, mem_wdata = 0; timeout counter = 0.
- Reset mid-operation abandons the transaction. mem_req is low after that edge, no done is issued, and rdata is cleared.
- Byte lanes are little-endian: addr[1:0]=0 selects bits 7:0; a half at addr[1]=0 selects bits 15:0.
- FSM states: IDLE, RD, MERGE, WR, FIN.
- IDLE, on start (sampled at edge E0):
  - Check first: read_mem=write_mem, size=11, half with addr[0]=1, or word with addr[1:0]!=0 → FIN with err=1 and no memory access.
  - A start with read_mem=write_mem=0 counts as an error.
  - Otherwise latch addr, size, wdata and op.
  - Load, or word store → RD (load) or WR (store).
  - Sub-word store → RD.
- RD: mem_req=1, mem_we=0. On mem_ack:
  - Load: extract the lane, zero-extend into rdata, go to FIN.
  - Sub-word store: capture mem_rdata, go to MERGE.
- MERGE: mem_req=0 for exactly one cycle. Replace the addressed lane of the captured word with the latched wdata, then go to WR.
- WR: mem_req=1, mem_we=1, mem_wdata = merged or full word. On mem_ack → FIN.
- FIN: done=1 and busy=0 for one cycle, err as determined, then IDLE. A start in FIN is ignored. A new start is accepted in IDLE only.
- Latency with ack in the first req cycle (start at E0):
  - LW/LBU/LHU/SW: done high in the cycle after E2.
  - SB/SH: done high in the cycle after E4.
  - Error path: done in the cycle after E1.
- Timeout: the counter clears on entry to RD/WR and increments each cycle with mem_req=1 and no ack. Reaching TIMEOUT_CYC → mem_req drops, FIN with err=1, rdata unchanged.
- mem_ack seen while mem_req=0 is ignored.

Decomposition:
- Shared package lsu_pkg holds:
  - SIZE_BYTE=2'b00, SIZE_HALF=2'b01, SIZE_WORD=2'b10
  - FSM state enum (IDLE, RD, MERGE, WR, FIN)
  - TIMEOUT_CYC default
- One combinational sub-module, lsu_lane_mux. It takes word, addr[1:0], size and store data, and outputs the zero-extended load value and the merged store word. It is shared by the RD and MERGE paths.

Test Plan:
- LBU addr=0x103, memory word 0xAABBCCDD, ack after 1 cycle → one RD req at mem_addr=0x100; done with rdata=0x000000AA, err=0.
- LHU addr=0x102, same word → rdata=0x0000AABB. LW addr=0x100 → rdata=0xAABBCCDD; done the cycle after E2.
- SB addr=0x101, wdata=0x55, memory 0x11223344 → read 0x100, one idle cycle, then write mem_wdata=0x11225544 with mem_we=1; done; exactly two req phases.
- Misaligned LW addr=0x102, and SH addr=0x101 → no mem_req; done with err=1 the cycle after E1. start with size=11 → same response.
- TIMEOUT_CYC=4 with mem_ack tied low → mem_req high for 4 cycles then low; done with err=1; a following LW completes normally.
- rst asserted while in WR → mem_req=0 and busy=0 after that edge; no done pulse. start during busy is ignored (no second transaction).
